// File: rtl/psram_phase_cal.sv
// PSRAM rPLL phase calibration: resets the PLL, sweeps PSDA over 16 phases,
// and parks on the centre of the widest circular pass window. Optional pass_map port: PHASE_CAL_MAP_EN.
module psram_phase_cal #(
    parameter logic [3:0] DEFAULT_PSDA   = 4'b0100,
    parameter int         PLL_RST_CYCLES = 16,
    parameter int         LOCK_TIMEOUT   = 65535,
    parameter int         SETTLE_CYCLES  = 256
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        pll_lock,
    output logic        pll_reset,
    output logic [3:0]  psda,
    output logic        test_req,
    input  logic        test_ack,
    input  logic        test_pass,
    output logic        busy,
    output logic        done,
    output logic        cal_ok,
    output logic        lock_err,
    output logic [3:0]  best_phase,
`ifdef PHASE_CAL_MAP_EN
    output logic [15:0] pass_map,
`endif
    output logic [4:0]  win_len
);

    typedef enum logic [2:0] {
        IDLE, PLL_RST, WAIT_LOCK, SETTLE, TEST, NEXT, SELECT, FINISH
    } state_t;

    localparam logic [15:0] C_RST_LAST    = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] C_LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] C_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt;
    logic [3:0]  r_p;
    logic [15:0] r_map;
    logic        r_lock_drop;
    logic        r_pll_reset, r_test_req, r_busy, r_done, r_cal_ok, r_lock_err;
    logic [3:0]  r_psda, r_best_phase;
    logic [4:0]  r_win_len;

    // Ring-scan state used by SELECT
    logic [5:0]  r_idx;
    logic [3:0]  r_run_start, r_best_start;
    logic [4:0]  r_run_len, r_best_len;

    logic        w_bit;
    logic [4:0]  w_run_len_inc;
    logic [3:0]  w_run_start_cur;
    logic [3:0]  w_best_calc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every comb output gets a default first, otherwise a missed branch infers a latch.
        w_state_nxt     = r_state;
        w_bit           = r_map[r_idx[3:0]];
        w_run_len_inc   = (r_run_len == 5'd16) ? 5'd16 : r_run_len + 5'd1;
        w_run_start_cur = (r_run_len == 5'd0) ? r_idx[3:0] : r_run_start;
        w_best_calc     = r_best_start + r_best_len[4:1];
        if (r_best_len == 5'd0 || r_best_len == 5'd16) w_best_calc = DEFAULT_PSDA;
        case (r_state)
            IDLE:      if (start) w_state_nxt = PLL_RST;
            PLL_RST:   if (r_cnt == C_RST_LAST) w_state_nxt = WAIT_LOCK;
            WAIT_LOCK: if (pll_lock) w_state_nxt = SETTLE;
                       else if (r_cnt == C_LOCK_LAST) w_state_nxt = FINISH;
            SETTLE:    if (pll_lock && r_cnt == C_SETTLE_LAST) w_state_nxt = TEST;
            TEST:      if (test_ack) w_state_nxt = NEXT;
            NEXT:      w_state_nxt = (r_p == 4'd15) ? SELECT : SETTLE;
            SELECT:    if (r_idx == 6'd32) w_state_nxt = FINISH;
            FINISH:    w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt        <= '0;
            r_p          <= '0;
            // NOTE: the pass map is a plain register, so it is reset with everything else and no stale results survive.
            r_map        <= '0;
            r_lock_drop  <= 1'b0;
            r_pll_reset  <= 1'b0;
            r_test_req   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cal_ok     <= 1'b0;
            r_lock_err   <= 1'b0;
            r_psda       <= DEFAULT_PSDA;
            r_best_phase <= DEFAULT_PSDA;
            r_win_len    <= '0;
            r_idx        <= '0;
            r_run_start  <= '0;
            r_run_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else begin
            // Shared counter restarts on every state change; settle restarts on lock loss.
            if (w_state_nxt != r_state || r_state == IDLE) r_cnt <= '0;
            else if (r_state == SETTLE && !pll_lock)       r_cnt <= '0;
            else                                           r_cnt <= r_cnt + 16'd1;

            case (r_state)
                IDLE: if (start) begin
                    r_busy      <= 1'b1;
                    r_done      <= 1'b0;
                    r_cal_ok    <= 1'b0;
                    r_lock_err  <= 1'b0;
                    r_map       <= '0;
                    r_p         <= '0;
                    r_best_len  <= '0;
                    r_pll_reset <= 1'b1;
                end
                PLL_RST: if (w_state_nxt == WAIT_LOCK) r_pll_reset <= 1'b0;
                WAIT_LOCK: begin
                    if (pll_lock)                     r_psda     <= 4'd0;
                    else if (w_state_nxt == FINISH)   r_lock_err <= 1'b1;
                end
                SETTLE: if (w_state_nxt == TEST) begin
                    r_test_req  <= 1'b1;
                    r_lock_drop <= 1'b0;
                end
                TEST: begin
                    if (!pll_lock) r_lock_drop <= 1'b1;
                    if (test_ack) begin
                        r_map[r_p] <= test_pass & pll_lock & ~r_lock_drop;
                        r_test_req <= 1'b0;
                    end
                end
                NEXT: begin
                    if (r_p != 4'd15) begin
                        r_p    <= r_p + 4'd1;
                        r_psda <= r_p + 4'd1;
                    end else begin
                        r_idx        <= '0;
                        r_run_start  <= '0;
                        r_run_len    <= '0;
                        r_best_start <= '0;
                        r_best_len   <= '0;
                    end
                end
                SELECT: if (r_idx != 6'd32) begin
                    r_idx <= r_idx + 6'd1;
                    if (w_bit) begin
                        r_run_start <= w_run_start_cur;
                        r_run_len   <= w_run_len_inc;
                        // Strict compare keeps the earliest-found run on ties
                        if (w_run_len_inc > r_best_len) begin
                            r_best_len   <= w_run_len_inc;
                            r_best_start <= w_run_start_cur;
                        end
                    end else begin
                        r_run_len <= '0;
                    end
                end
                FINISH: begin
                    r_psda       <= w_best_calc;
                    r_best_phase <= w_best_calc;
                    r_win_len    <= r_best_len;
                    r_cal_ok     <= (r_best_len != 5'd0);
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign pll_reset  = r_pll_reset;
    assign psda       = r_psda;
    assign test_req   = r_test_req;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cal_ok     = r_cal_ok;
    assign lock_err   = r_lock_err;
    assign best_phase = r_best_phase;
    assign win_len    = r_win_len;
`ifdef PHASE_CAL_MAP_EN
    assign pass_map   = r_map;
`endif

endmodule

// File: tb/tb_psram_phase_cal.sv
// Directed self-checking bench for psram_phase_cal; the bench itself plays the rPLL and the PSRAM test engine.
module tb_psram_phase_cal;

    logic        clk = 1'b0;
    logic        resetn, start, pll_lock, test_ack, test_pass;
    logic        pll_reset, test_req, busy, done, cal_ok, lock_err;
    logic [3:0]  psda, best_phase;
    logic [4:0]  win_len;
`ifdef PHASE_CAL_MAP_EN
    logic [15:0] pass_map;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Results of the last run_cal call
    int rst_hi, n_req, settle_meas;
    bit timed_out, aborted;

    localparam int CYC_BUDGET = 20000;

    psram_phase_cal #(.LOCK_TIMEOUT(1000)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .psda       (psda),
        .test_req   (test_req),
        .test_ack   (test_ack),
        .test_pass  (test_pass),
        .busy       (busy),
        .done       (done),
        .cal_ok     (cal_ok),
        .lock_err   (lock_err),
        .best_phase (best_phase),
`ifdef PHASE_CAL_MAP_EN
        .pass_map   (pass_map),
`endif
        .win_len    (win_len)
    );

    always #5 clk = ~clk;

    // One calibration: pulse start, model PLL lock and the test engine (pass = pat[psda]), stop on done.
    task automatic run_cal(input logic [15:0] pat, input int lock_delay, input bit drop5,
                           input bit extra_starts, input int abort_phase);
        bit seen_rst = 0, req_prev = 0, lock_restore = 0;
        bit settle_done = 0, measuring = 0, test_drop_done = 0;
        int since = 0, ack_cnt = 0, ph5_cnt = 0;
        rst_hi = 0; n_req = 0; settle_meas = -1; timed_out = 1; aborted = 0;
        pll_lock = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        if (pll_reset) rst_hi++;
        for (int cyc = 0; cyc < CYC_BUDGET; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (test_ack) test_ack = 1'b0;
            if (lock_restore) begin pll_lock = 1'b1; lock_restore = 0; end
            if (pll_reset) begin
                seen_rst = 1; pll_lock = 1'b0; rst_hi++;
            end else if (seen_rst) begin
                since++;
                if (since == lock_delay) pll_lock = 1'b1;
            end
            if (done) begin timed_out = 0; break; end
            if (abort_phase >= 0 && busy && psda == 4'(abort_phase)) begin
                resetn = 1'b0; pll_lock = 1'b0; aborted = 1; timed_out = 0; break;
            end
            if (test_req && !req_prev) begin n_req++; ack_cnt = 3; end
            req_prev = test_req;
            if (drop5 && psda == 4'd5) begin
                if (measuring) begin
                    settle_meas++;
                    if (test_req) begin measuring = 0; settle_done = 1; end
                end
                if (!settle_done && !measuring && !test_req) begin
                    ph5_cnt++;
                    if (ph5_cnt == 100) pll_lock = 1'b0;
                    if (ph5_cnt == 110) begin pll_lock = 1'b1; settle_meas = 0; measuring = 1; end
                end
                if (test_req && !test_drop_done) begin
                    pll_lock = 1'b0; lock_restore = 1; test_drop_done = 1;
                end
            end
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin test_ack = 1'b1; test_pass = pat[psda]; end
            end
            if (extra_starts && busy && (cyc % 97) == 50) start = 1'b1;
        end
        start = 1'b0;
        test_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; pll_lock = 1'b0; test_ack = 1'b0; test_pass = 1'b0;
        #12;
        n_total++; if (psda !== 4'b0100) $display("FAIL rst_psda got %0d want 4", psda); else n_pass++;
        n_total++; if (pll_reset !== 1'b0) $display("FAIL rst_pll_reset got %0b want 0", pll_reset); else n_pass++;
        @(negedge clk) resetn = 1'b1;
        repeat (50) @(negedge clk);
        n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_busy_done got %0b%0b want 00", busy, done); else n_pass++;
        n_total++; if (psda !== 4'b0100 || pll_reset !== 1'b0 || test_req !== 1'b0)
            $display("FAIL idle_outputs got psda=%0d rst=%0b req=%0b want 4 0 0", psda, pll_reset, test_req); else n_pass++;
        n_total++; if (best_phase !== 4'd4 || win_len !== 5'd0 || cal_ok !== 1'b0 || lock_err !== 1'b0)
            $display("FAIL idle_results got best=%0d len=%0d ok=%0b err=%0b want 4 0 0 0", best_phase, win_len, cal_ok, lock_err); else n_pass++;
    endtask

    task automatic check_result(input string tag, input int exp_len, input int exp_best, input bit exp_ok);
        n_total++; if (timed_out) $display("FAIL %s_timeout got no done want done", tag); else n_pass++;
        n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL %s_done got done=%0b busy=%0b want 1 0", tag, done, busy); else n_pass++;
        n_total++; if (win_len !== 5'(exp_len)) $display("FAIL %s_win_len got %0d want %0d", tag, win_len, exp_len); else n_pass++;
        n_total++; if (best_phase !== 4'(exp_best)) $display("FAIL %s_best got %0d want %0d", tag, best_phase, exp_best); else n_pass++;
        n_total++; if (psda !== 4'(exp_best)) $display("FAIL %s_psda got %0d want %0d", tag, psda, exp_best); else n_pass++;
        n_total++; if (cal_ok !== exp_ok) $display("FAIL %s_cal_ok got %0b want %0b", tag, cal_ok, exp_ok); else n_pass++;
        n_total++; if (n_req != 16) $display("FAIL %s_n_req got %0d want 16", tag, n_req); else n_pass++;
        n_total++; if (lock_err !== 1'b0) $display("FAIL %s_lock_err got %0b want 0", tag, lock_err); else n_pass++;
    endtask

    task automatic test_basic_window();
        run_cal(16'h03F8, 100, 0, 0, -1);
        n_total++; if (rst_hi != 16) $display("FAIL t2_pll_reset_cycles got %0d want 16", rst_hi); else n_pass++;
        check_result("t2", 7, 6, 1);
`ifdef PHASE_CAL_MAP_EN
        n_total++; if (pass_map !== 16'h03F8) $display("FAIL t2_pass_map got %h want 03f8", pass_map); else n_pass++;
`endif
    endtask

    task automatic test_wrap_and_tie();
        run_cal(16'hE007, 5, 0, 0, -1);
        check_result("wrap", 6, 0, 1);
        run_cal(16'h070E, 5, 0, 0, -1);
        check_result("tie", 3, 2, 1);
    endtask

    task automatic test_all_fail_all_pass();
        run_cal(16'h0000, 5, 0, 0, -1);
        check_result("allfail", 0, 4, 0);
        run_cal(16'hFFFF, 5, 0, 0, -1);
        check_result("allpass", 16, 4, 1);
    endtask

    task automatic test_lock_faults();
        run_cal(16'hFFFF, -1, 0, 0, -1);
        n_total++; if (timed_out || done !== 1'b1) $display("FAIL to_done got done=%0b want 1", done); else n_pass++;
        n_total++; if (lock_err !== 1'b1 || cal_ok !== 1'b0) $display("FAIL to_flags got err=%0b ok=%0b want 1 0", lock_err, cal_ok); else n_pass++;
        n_total++; if (n_req != 0) $display("FAIL to_no_req got %0d want 0", n_req); else n_pass++;
        n_total++; if (psda !== 4'd4) $display("FAIL to_psda got %0d want 4", psda); else n_pass++;
        // Phase 5 loses lock in SETTLE and again in TEST; ring 6..15,0..4 passes.
        run_cal(16'hFFFF, 5, 1, 0, -1);
        n_total++; if (settle_meas != 256) $display("FAIL drop_settle_restart got %0d want 256", settle_meas); else n_pass++;
        check_result("drop", 15, 13, 1);
`ifdef PHASE_CAL_MAP_EN
        n_total++; if (pass_map !== 16'hFFDF) $display("FAIL drop_pass_map got %h want ffdf", pass_map); else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        run_cal(16'h03F8, 5, 0, 1, 8);
        n_total++; if (!aborted) $display("FAIL abort_reached got 0 want 1"); else n_pass++;
        #1;
        n_total++; if (psda !== 4'd4 || busy !== 1'b0 || done !== 1'b0 || pll_reset !== 1'b0 || test_req !== 1'b0)
            $display("FAIL abort_ctrl got psda=%0d busy=%0b done=%0b rst=%0b req=%0b want 4 0 0 0 0",
                     psda, busy, done, pll_reset, test_req); else n_pass++;
        n_total++; if (best_phase !== 4'd4 || win_len !== 5'd0 || cal_ok !== 1'b0 || lock_err !== 1'b0)
            $display("FAIL abort_results got best=%0d len=%0d ok=%0b err=%0b want 4 0 0 0",
                     best_phase, win_len, cal_ok, lock_err); else n_pass++;
        @(negedge clk) resetn = 1'b1;
        repeat (3) @(negedge clk);
        run_cal(16'h03F8, 5, 0, 1, -1);
        n_total++; if (rst_hi != 16) $display("FAIL b2b_pll_reset_cycles got %0d want 16", rst_hi); else n_pass++;
        check_result("b2b", 7, 6, 1);
        repeat (5) @(negedge clk);
        n_total++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_done_held got done=%0b busy=%0b want 1 0", done, busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_wrap_and_tie();
        test_all_fail_all_pass();
        test_lock_faults();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
